// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and helpers for the FIFO read-side packer
package fifo_rd_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {FILL, HOLD, FLUSH} state_t;
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    return 8'((16'd1 << n) - 16'd1);
  endfunction
endpackage

// File: rtl/rd_word_outreg.sv
// rd_word_outreg: stream output register; data/keep stay stable until accepted
module rd_word_outreg #(
  parameter int W = 32,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_data,
  input  logic [K-1:0] ld_keep,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic [K-1:0] keep,
  output logic         valid,
  output logic         free
);
  assign free = ~valid | ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= ld_data;
      keep  <= ld_keep;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pulls bytes from the async FIFO read port and packs them into
// little-endian words, releasing partial words on flush request or idle timeout.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic                    fifo_empty,
  input  logic [BYTE_W-1:0]       fifo_rd_data,
  output logic                    fifo_rd_en,
  output logic [BYTE_W*BYTES-1:0] out_data,
  output logic [BYTES-1:0]        out_keep,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush_req,
  output logic                    flush_done
);
  localparam int CW = $clog2(BYTES + 1);
  localparam int IW = $clog2(BYTES);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic [BYTES-1:0][BYTE_W-1:0] asm_buf;
  logic pend, flush_pending, fl_user, full, out_free, load, tick, to_fire, fl_clear;
  assign full = cnt == CW'(BYTES);
  assign tick = (cnt != '0) & ~pend & fifo_empty;
  assign to_fire = (TIMEOUT != 0) && tick && (timer == TW'(TIMEOUT - 1));
  always_ff @(posedge rd_clk) begin
    if (rd_rst) state <= FILL;
    else state <= state_n;
  end
  // a full word always drains before a pending flush is entered
  always_comb begin
    state_n = state == HOLD  ? (out_free ? FILL : HOLD) :
              state == FLUSH ? (cnt == '0 ? FILL : FLUSH) :
              full           ? (out_free ? FILL : HOLD) :
              (flush_pending & ~pend) ? FLUSH : FILL;
  end
  always_comb begin
    fifo_rd_en = ~rd_rst & (state == FILL) & ~fifo_empty & ~flush_pending &
                 (int'(cnt) + int'(pend) < BYTES);
    load       = out_free & (state == FLUSH ? cnt != '0 : full);
    fl_clear   = (state == FLUSH) & (cnt == '0);
    flush_done = ~rd_rst & fl_clear & fl_user;
  end
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      cnt           <= '0;
      pend          <= 1'b0;
      timer         <= '0;
      flush_pending <= 1'b0;
      fl_user       <= 1'b0;
      asm_buf       <= '0;
    end else begin
      pend  <= fifo_rd_en & ~fifo_empty;
      timer <= tick ? timer + 1'b1 : '0;
      if (fl_clear) begin
        flush_pending <= 1'b0;
        fl_user       <= 1'b0;
      end else if (~flush_pending & (flush_req | to_fire)) begin
        flush_pending <= 1'b1;
        fl_user       <= flush_req;
      end
      if (load) begin
        cnt     <= '0;
        asm_buf <= '0;
      end else if (pend) begin
        asm_buf[cnt[IW-1:0]] <= fifo_rd_data;
        cnt                  <= cnt + 1'b1;
      end
    end
  end
  rd_word_outreg #(.W(BYTE_W * BYTES), .K(BYTES)) u_outreg (
    .clk     (rd_clk),
    .rst     (rd_rst),
    .load    (load),
    .ld_data (asm_buf),
    .ld_keep (BYTES'(keep_mask(4'(cnt)))),
    .ready   (out_ready),
    .data    (out_data),
    .keep    (out_keep),
    .valid   (out_valid),
    .free    (out_free)
  );
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: scenario tasks against a byte-queue FIFO model and word-grouping reference
module tb_fifo_rd_packer;
  logic clk = 1'b0, rst = 1'b1, ordy = 1'b0, freq = 1'b0;
  logic emp = 1'b1, emp0 = 1'b1;
  logic [7:0] rdd = 8'h0, rdd0 = 8'h0;
  logic rd_en, rd_en0, ov, ov0, fdone, fdone0;
  logic [31:0] od, od0;
  logic [3:0] ok, ok0;
  logic [7:0] fm [512];
  logic [7:0] fm0 [512];
  int wp = 0, rp = 0, wp0 = 0, rp0 = 0;
  logic [31:0] rwd [64];
  logic [3:0] rwk [64];
  int nrw = 0, ov_cycles = 0, done_cnt = 0, done_at = 0, hold_bad = 0, ov0_cycles = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [31:0] pd = 32'h0;
  logic [3:0] pk = 4'h0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fifo_rd_packer #(.BYTES(4), .TIMEOUT(16), .TW(8)) dut (
    .rd_clk(clk), .rd_rst(rst), .fifo_empty(emp), .fifo_rd_data(rdd), .fifo_rd_en(rd_en),
    .out_data(od), .out_keep(ok), .out_valid(ov), .out_ready(ordy),
    .flush_req(freq), .flush_done(fdone));

  fifo_rd_packer #(.BYTES(4), .TIMEOUT(0), .TW(8)) dut0 (
    .rd_clk(clk), .rd_rst(rst), .fifo_empty(emp0), .fifo_rd_data(rdd0), .fifo_rd_en(rd_en0),
    .out_data(od0), .out_keep(ok0), .out_valid(ov0), .out_ready(ordy),
    .flush_req(freq), .flush_done(fdone0));

  // FIFO models: data one cycle after an accepted read, registered empty flag
  always @(posedge clk) begin
    if (rd_en && !emp) begin rdd <= fm[rp]; rp = rp + 1; end
    emp <= (rp == wp);
    if (rd_en0 && !emp0) begin rdd0 <= fm0[rp0]; rp0 = rp0 + 1; end
    emp0 <= (rp0 == wp0);
  end

  always @(posedge clk) begin
    if (rst) pv = 1'b0;
    else begin
      if (pv && !pr && (!ov || od !== pd || ok !== pk)) hold_bad++;
      if (ov && ordy && nrw < 64) begin rwd[nrw] = od; rwk[nrw] = ok; nrw++; end
      if (ov) ov_cycles++;
      if (ov0) ov0_cycles++;
      if (fdone) begin done_cnt++; done_at = nrw; end
      pv = ov; pr = ordy; pd = od; pk = ok;
    end
  end

  task automatic push(input logic [7:0] b);
    fm[wp] = b; wp++;
  endtask

  task automatic push0(input logic [7:0] b);
    fm0[wp0] = b; wp0++;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget && nrw < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ov); end
    total++; if (od !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", od); end
    total++; if (ok !== 4'h0) begin bad++; $display("FAIL reset_keep got=%h exp=0", ok); end
    total++; if (fdone !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", fdone); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rden got=%b exp=0", rd_en); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int b, v;
    b = nrw; v = ov_cycles; ordy = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_words(b + 1, 40);
    repeat (5) @(negedge clk);
    total++; if (nrw !== b + 1) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", nrw - b, 1); end
    total++; if (rwd[b] !== 32'h44332211) begin bad++; $display("FAIL basic_data got=%h exp=44332211", rwd[b]); end
    total++; if (rwk[b] !== 4'hF) begin bad++; $display("FAIL basic_keep got=%h exp=f", rwk[b]); end
    total++; if (ov_cycles !== v + 1) begin bad++; $display("FAIL basic_valid_cycles got=%0d exp=1", ov_cycles - v); end
  endtask

  task automatic test_backpressure;
    int b, r0, h0;
    logic [31:0] exp_w;
    b = nrw; r0 = rp; h0 = hold_bad; ordy = 1'b0;
    for (int i = 0; i < 12; i++) push(8'(i));
    repeat (20) @(negedge clk);
    total++; if (nrw !== b) begin bad++; $display("FAIL bp_no_accept got=%0d exp=0", nrw - b); end
    total++; if (ov !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", ov); end
    total++; if (od !== 32'h03020100) begin bad++; $display("FAIL bp_held_data got=%h exp=03020100", od); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL bp_rden got=%b exp=0", rd_en); end
    total++; if (rp - r0 !== 8) begin bad++; $display("FAIL bp_bytes_read got=%0d exp=8", rp - r0); end
    ordy = 1'b1;
    wait_words(b + 3, 60);
    repeat (5) @(negedge clk);
    total++; if (nrw !== b + 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", nrw - b); end
    for (int w = 0; w < 3; w++) begin
      exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      total++; if (rwd[b+w] !== exp_w) begin bad++; $display("FAIL bp_word%0d got=%h exp=%h", w, rwd[b+w], exp_w); end
    end
    total++; if (hold_bad !== h0) begin bad++; $display("FAIL bp_hold_stable got=%0d exp=0", hold_bad - h0); end
  endtask

  task automatic test_flush;
    int b, d0, v1;
    b = nrw; d0 = done_cnt;
    push(8'hAA); push(8'hBB);
    repeat (6) @(negedge clk);
    freq = 1'b1; @(negedge clk); freq = 1'b0;
    wait_words(b + 1, 30);
    repeat (4) @(negedge clk);
    total++; if (nrw !== b + 1) begin bad++; $display("FAIL flush_count got=%0d exp=1", nrw - b); end
    total++; if (rwd[b] !== 32'h0000BBAA) begin bad++; $display("FAIL flush_data got=%h exp=0000bbaa", rwd[b]); end
    total++; if (rwk[b] !== 4'b0011) begin bad++; $display("FAIL flush_keep got=%b exp=0011", rwk[b]); end
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL flush_done_cnt got=%0d exp=1", done_cnt - d0); end
    total++; if (done_at !== b + 1) begin bad++; $display("FAIL flush_done_order got=%0d exp=%0d", done_at, b + 1); end
    d0 = done_cnt; v1 = ov_cycles;
    freq = 1'b1; @(negedge clk); freq = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL flush_empty_done got=%0d exp=1", done_cnt - d0); end
    total++; if (ov_cycles !== v1) begin bad++; $display("FAIL flush_empty_valid got=%0d exp=0", ov_cycles - v1); end
  endtask

  task automatic test_race;
    int b, d0;
    b = nrw; d0 = done_cnt;
    push(8'h01);
    repeat (6) @(negedge clk);
    push(8'hCC);
    @(negedge clk);
    total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL race_rden got=%b exp=1", rd_en); end
    freq = 1'b1; @(negedge clk); freq = 1'b0;
    wait_words(b + 1, 30);
    repeat (4) @(negedge clk);
    total++; if (rwd[b] !== 32'h0000CC01) begin bad++; $display("FAIL race_data got=%h exp=0000cc01", rwd[b]); end
    total++; if (rwk[b] !== 4'b0011) begin bad++; $display("FAIL race_keep got=%b exp=0011", rwk[b]); end
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL race_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_timeout;
    int b, d0;
    b = nrw; d0 = done_cnt;
    push(8'h10); push(8'h20); push(8'h30);
    push0(8'h10); push0(8'h20); push0(8'h30);
    repeat (20) @(negedge clk);
    total++; if (nrw !== b || ov !== 1'b0) begin bad++; $display("FAIL to_early got=%0d/%b exp=0/0", nrw - b, ov); end
    wait_words(b + 1, 40);
    repeat (4) @(negedge clk);
    total++; if (rwd[b] !== 32'h00302010) begin bad++; $display("FAIL to_data got=%h exp=00302010", rwd[b]); end
    total++; if (rwk[b] !== 4'b0111) begin bad++; $display("FAIL to_keep got=%b exp=0111", rwk[b]); end
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL to_no_done got=%0d exp=0", done_cnt - d0); end
    repeat (50) @(negedge clk);
    total++; if (rp0 !== 3) begin bad++; $display("FAIL to0_bytes_read got=%0d exp=3", rp0); end
    total++; if (ov0_cycles !== 0) begin bad++; $display("FAIL to0_no_output got=%0d exp=0", ov0_cycles); end
  endtask

  task automatic test_reset_mid;
    int b;
    b = nrw;
    push(8'hE1); push(8'hE2);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    @(negedge clk);
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", ov); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL rmid_rden got=%b exp=0", rd_en); end
    rst = 1'b0;
    wait_words(b + 1, 40);
    repeat (10) @(negedge clk);
    total++; if (nrw !== b + 1) begin bad++; $display("FAIL rmid_count got=%0d exp=1", nrw - b); end
    total++; if (rwd[b] !== 32'h04030201) begin bad++; $display("FAIL rmid_data got=%h exp=04030201", rwd[b]); end
    total++; if (rwk[b] !== 4'hF) begin bad++; $display("FAIL rmid_keep got=%h exp=f", rwk[b]); end
  endtask

  task automatic test_random;
    int b, h0, n;
    logic [7:0] ex [40];
    logic [31:0] exp_w;
    b = nrw; h0 = hold_bad; n = 0;
    while (n < 40) begin
      @(negedge clk);
      ordy = ($urandom % 4) != 0;
      if ($urandom % 3 != 0) begin ex[n] = 8'($urandom); push(ex[n]); n++; end
    end
    @(negedge clk); ordy = 1'b1;
    wait_words(b + 10, 200);
    repeat (5) @(negedge clk);
    total++; if (nrw !== b + 10) begin bad++; $display("FAIL rnd_count got=%0d exp=10", nrw - b); end
    for (int w = 0; w < 10; w++) begin
      exp_w = {ex[4*w+3], ex[4*w+2], ex[4*w+1], ex[4*w]};
      total++; if (rwd[b+w] !== exp_w || rwk[b+w] !== 4'hF) begin
        bad++; $display("FAIL rnd_word%0d got=%h/%h exp=%h/f", w, rwd[b+w], rwk[b+w], exp_w);
      end
    end
    total++; if (hold_bad !== h0) begin bad++; $display("FAIL rnd_hold_stable got=%0d exp=0", hold_bad - h0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_flush;
    test_race;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
